// File: rtl/des_pkg.sv
// =============================================================================
//  Module : des_pkg
//  Brief  : DES permutation tables, S-boxes, key-schedule helpers and shared types.
//  Rev    : 1.0
// =============================================================================
`default_nettype none

package des_pkg;

    localparam int DES_ROUNDS = 16;

    typedef logic [0:31] half_t;
    typedef logic [0:27] cd_t;
    typedef logic [0:47] subkey_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // All table entries use FIPS 1-based bit numbering.
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int E_TAB [0:47] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TAB [0:31] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Entry 0 is padding so the table is indexed directly by round number 1..16.
    localparam logic [1:0] SHIFT [0:16] = '{
        2'd0,
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Row-major: index = {b1, b6, b2..b5}.
    localparam int SBOX [0:7][0:63] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    // One key-schedule step ahead of round rnd. Decrypt walks the schedule
    // backwards: round 1 reuses C0/D0 (= C16/D16), later rounds rotate right.
    function automatic cd_t key_step(input cd_t v, input logic [4:0] rnd, input logic dec);
        cd_t        o;
        logic [1:0] n;
        o = v;
        if (!dec) begin
            n = SHIFT[rnd];
            o = (n == 2'd1) ? {v[1:27], v[0]} : {v[2:27], v[0:1]};
        end else if (rnd != 5'd1) begin
            n = SHIFT[5'd18 - rnd];
            o = (n == 2'd1) ? {v[27], v[0:26]} : {v[26:27], v[0:25]};
        end
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/des_f.sv
// =============================================================================
//  Module : des_f
//  Brief  : Combinational DES round function f(R, K) = P(S(E(R) ^ K)).
//  Rev    : 1.0
// =============================================================================
`default_nettype none

module des_f
    import des_pkg::*;
(
    input  half_t   i_r,
    input  subkey_t i_k,
    output half_t   o_f
);

    subkey_t w_e;
    subkey_t w_x;
    half_t   w_s;

    for (genvar i = 0; i < 48; i++) begin : g_e
        assign w_e[i] = i_r[E_TAB[i] - 1];
    end

    assign w_x = w_e ^ i_k;

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        logic [5:0] w_idx;
        // Outer bits pick the row, inner four the column.
        assign w_idx          = {w_x[6*g], w_x[6*g+5], w_x[6*g+1 +: 4]};
        assign w_s[4*g +: 4]  = 4'(SBOX[g][w_idx]);
    end

    for (genvar i = 0; i < 32; i++) begin : g_p
        assign o_f[i] = w_s[P_TAB[i] - 1];
    end

endmodule

`default_nettype wire

// File: rtl/des_round_iter.sv
// =============================================================================
//  Module : des_round_iter
//  Brief  : Iterative 16-round DES Feistel engine, on-the-fly key schedule,
//           start/done handshake. Optional key parity check: DES_KEY_PARITY_EN.
//  Rev    : 1.0
// =============================================================================
`default_nettype none

module des_round_iter
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [0:63] key,
    input  logic [0:63] data_in,
    output logic [0:63] data_out,
    output logic        busy,
    output logic        done,
    output logic        key_err
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
        $error("des_round_iter: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t      state_q, state_d;
    half_t       l_q, l_d, r_q, r_d;
    cd_t         c_q, c_d, d_q, d_d;
    logic        dir_q, dir_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [0:63] data_out_q, data_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        key_ok;

    logic [0:55] w_cd0;
    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign w_cd0[i] = key[PC1[i] - 1];
    end

`ifdef DES_KEY_PARITY_EN
    logic key_err_q, key_err_d;
    logic [7:0] w_byte_odd;
    for (genvar b = 0; b < 8; b++) begin : g_par
        assign w_byte_odd[b] = ^key[8*b +: 8];
    end
    assign key_ok  = &w_byte_odd;
    assign key_err = key_err_q;
`else
    logic w_key_unused;
    assign w_key_unused = ^key;
    assign key_ok       = 1'b1;
    assign key_err      = 1'b0;
`endif

    // Unrolled round chain: stage 0 is the register contents.
    half_t l_s [0:ROUNDS_PER_CYCLE];
    half_t r_s [0:ROUNDS_PER_CYCLE];
    cd_t   c_s [0:ROUNDS_PER_CYCLE];
    cd_t   d_s [0:ROUNDS_PER_CYCLE];

    assign l_s[0] = l_q;
    assign r_s[0] = r_q;
    assign c_s[0] = c_q;
    assign d_s[0] = d_q;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        logic [4:0]  w_idx;
        logic [0:55] w_cd;
        subkey_t     w_k;
        half_t       w_f;

        assign w_idx    = rnd_q + 5'(g + 1);
        assign c_s[g+1] = key_step(c_s[g], w_idx, dir_q);
        assign d_s[g+1] = key_step(d_s[g], w_idx, dir_q);
        assign w_cd     = {c_s[g+1], d_s[g+1]};

        for (genvar j = 0; j < 48; j++) begin : g_pc2
            assign w_k[j] = w_cd[PC2[j] - 1];
        end

        des_f u_f (
            .i_r (r_s[g]),
            .i_k (w_k),
            .o_f (w_f)
        );

        assign l_s[g+1] = r_s[g];
        assign r_s[g+1] = l_s[g] ^ w_f;
    end

    logic [4:0] w_rnd_nxt;
    assign w_rnd_nxt = rnd_q + 5'(ROUNDS_PER_CYCLE);

    always_comb begin
        state_d    = state_q;
        l_d        = l_q;
        r_d        = r_q;
        c_d        = c_q;
        d_d        = d_q;
        dir_d      = dir_q;
        rnd_d      = rnd_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef DES_KEY_PARITY_EN
        key_err_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef DES_KEY_PARITY_EN
                    key_err_d = !key_ok;
`endif
                    if (key_ok) begin
                        l_d     = data_in[0:31];
                        r_d     = data_in[32:63];
                        c_d     = w_cd0[0:27];
                        d_d     = w_cd0[28:55];
                        rnd_d   = 5'd0;
                        dir_d   = decrypt;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                l_d   = l_s[ROUNDS_PER_CYCLE];
                r_d   = r_s[ROUNDS_PER_CYCLE];
                c_d   = c_s[ROUNDS_PER_CYCLE];
                d_d   = d_s[ROUNDS_PER_CYCLE];
                rnd_d = w_rnd_nxt;
                if (w_rnd_nxt == 5'(DES_ROUNDS)) begin
                    // Final swap: preoutput is R16 || L16.
                    data_out_d = {r_s[ROUNDS_PER_CYCLE], l_s[ROUNDS_PER_CYCLE]};
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    rnd_d      = 5'd0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            l_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            dir_q      <= 1'b0;
            rnd_q      <= 5'd0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DES_KEY_PARITY_EN
            key_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            r_q        <= r_d;
            c_q        <= c_d;
            d_q        <= d_d;
            dir_q      <= dir_d;
            rnd_q      <= rnd_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DES_KEY_PARITY_EN
            key_err_q  <= key_err_d;
`endif
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

`default_nettype wire
